// File: rtl/sdfifo_blk_sequencer_if.sv
// FIFO read port and SD data-line TX handshake shared by the block sequencer
// (master), the TX sfifo and the TX engine (slave side).
interface sdfifo_blk_sequencer_if #(
    parameter int BW     = 32,
    parameter int LGFLEN = 4
);
    logic [LGFLEN:0] i_fifo_fill;
    logic            i_fifo_empty;
    logic [BW-1:0]   i_fifo_data;
    logic            o_fifo_rd;
    logic            o_tx_start;
    logic            o_tx_valid;
    logic            i_tx_ready;
    logic [BW-1:0]   o_tx_data;
    logic            o_tx_last;
    logic            i_tx_done;

    modport master (
        input  i_fifo_fill, i_fifo_empty, i_fifo_data, i_tx_ready, i_tx_done,
        output o_fifo_rd, o_tx_start, o_tx_valid, o_tx_data, o_tx_last
    );

    modport slave (
        output i_fifo_fill, i_fifo_empty, i_fifo_data, i_tx_ready, i_tx_done,
        input  o_fifo_rd, o_tx_start, o_tx_valid, o_tx_data, o_tx_last
    );
endinterface

// File: rtl/sdfifo_blk_sequencer.sv
// Drains a first-word-fall-through FIFO into the SD data TX engine as a run of
// fixed-size blocks, gating each block on FIFO fill and the engine's done report.
module sdfifo_blk_sequencer #(
    parameter int BW     = 32,
    parameter int LGFLEN = 4,
    parameter int LGBLK  = 7,
    parameter int LGNBLK = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [LGNBLK-1:0]      i_nblocks,
    input  logic [LGBLK:0]         i_blk_words,
    input  logic                   i_abort,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_aborted,
    output logic [LGNBLK-1:0]      o_blocks_left,
    sdfifo_blk_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FILL = 3'd1,
        ST_START     = 3'd2,
        ST_STREAM    = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    localparam logic [LGBLK:0]    FDEPTH = (LGBLK+1)'(1 << LGFLEN);
    localparam logic [LGBLK:0]    W_ONE  = {{LGBLK{1'b0}}, 1'b1};
    localparam logic [LGNBLK-1:0] N_ONE  = {{(LGNBLK-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [LGBLK:0]    blk_words_r;
    logic [LGBLK:0]    wcnt_r;
    logic [LGNBLK-1:0] blocks_left_r;
    logic              done_r;
    logic              aborted_r;

    logic [LGBLK:0]    thr_s;
    logic              fill_ok_s;
    logic              busy_s;
    logic              abort_s;
    logic              stream_s;
    logic              tx_valid_s;
    logic              xfer_s;

    // Start threshold: a whole block, or a full FIFO when the block is larger.
    always_comb begin
        thr_s = FDEPTH;
        if (blk_words_r < FDEPTH) begin
            thr_s = blk_words_r;
        end else begin
            thr_s = FDEPTH;
        end
    end

    assign fill_ok_s  = ({{(LGBLK+1){1'b0}}, bus.i_fifo_fill} >= {{(LGFLEN+1){1'b0}}, thr_s});
    assign busy_s     = (state_r != ST_IDLE);
    assign abort_s    = busy_s & i_abort;
    assign stream_s   = (state_r == ST_STREAM);
    // Abort gates the handshake in the same cycle so no word leaves the FIFO.
    assign tx_valid_s = stream_s & ~bus.i_fifo_empty & ~abort_s;
    assign xfer_s     = tx_valid_s & bus.i_tx_ready;

    assign bus.o_tx_valid = tx_valid_s;
    assign bus.o_fifo_rd  = xfer_s;
    assign bus.o_tx_start = (state_r == ST_START) & ~abort_s;
    assign bus.o_tx_data  = stream_s ? bus.i_fifo_data : {BW{1'b0}};
    assign bus.o_tx_last  = stream_s & (wcnt_r == W_ONE);

    assign o_busy        = busy_s;
    assign o_done        = done_r;
    assign o_aborted     = aborted_r;
    assign o_blocks_left = blocks_left_r;

    // Block sequencing FSM with transfer bookkeeping.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r       <= ST_IDLE;
            blk_words_r   <= {(LGBLK+1){1'b0}};
            wcnt_r        <= {(LGBLK+1){1'b0}};
            blocks_left_r <= {LGNBLK{1'b0}};
            done_r        <= 1'b0;
            aborted_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort_s) begin
                state_r   <= ST_IDLE;
                done_r    <= 1'b1;
                aborted_r <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (i_start) begin
                            aborted_r <= 1'b0;
                            if ((i_nblocks != {LGNBLK{1'b0}}) && (i_blk_words != {(LGBLK+1){1'b0}})) begin
                                blk_words_r   <= i_blk_words;
                                blocks_left_r <= i_nblocks;
                                state_r       <= ST_WAIT_FILL;
                            end else begin
                                done_r <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT_FILL: begin
                        if (fill_ok_s) begin
                            state_r <= ST_START;
                        end
                    end
                    ST_START: begin
                        wcnt_r  <= blk_words_r;
                        state_r <= ST_STREAM;
                    end
                    ST_STREAM: begin
                        if (xfer_s) begin
                            wcnt_r <= wcnt_r - W_ONE;
                            if (wcnt_r == W_ONE) begin
                                state_r <= ST_WAIT_DONE;
                            end
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (bus.i_tx_done) begin
                            blocks_left_r <= blocks_left_r - N_ONE;
                            if (blocks_left_r == N_ONE) begin
                                state_r <= ST_IDLE;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= ST_WAIT_FILL;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule
